// File: rtl/mem_responder.sv
// mem_responder: word-array memory responder for the LC-3b mem_* port.
// Wait-state FSM, byte-masked writes, registered read data and completion.
module mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy,
  output logic        proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_LOAD =
    CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            perr_q, perr_d;

  logic [15:0]     mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]     rd_word;
  logic            req;
  logic            commit;
  logic            wr_en;
  logic            rd_en;
  logic            unused_addr;

  // Bits above the word index and the byte offset only alias
  assign unused_addr = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

  assign idx     = mem_address[DEPTH_LOG2:1];
  assign req     = mem_read | mem_write;
  assign rd_word = mem_q[idx];

  // A simultaneous read+write resolves as a write
  assign wr_en = commit & mem_write & rst_n;
  assign rd_en = commit & ~mem_write & mem_read;

  // Next state, wait counter and commit decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data capture and sticky protocol error
  always_comb begin
    rdata_d = rdata_q;
    perr_d  = perr_q;
    unique case (1'b1)
      rd_en:   rdata_d = rd_word;
      default: rdata_d = rdata_q;
    endcase
    if (commit && mem_read && mem_write) begin
      perr_d = 1'b1;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Word array, byte-lane writes, contents not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (mem_byte_enable[0]) begin
        mem_q[idx][7:0] <= mem_wdata[7:0];
      end
      if (mem_byte_enable[1]) begin
        mem_q[idx][15:8] <= mem_wdata[15:8];
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (2 and 0 wait states) driven by
// directed and random transactions against a transaction-level model.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [1:0]  be_s   [2];
  logic [15:0] addr_s [2];
  logic [15:0] wdat_s [2];
  logic [15:0] rdat_s [2];
  logic        resp_s [2];
  logic        bsy_s  [2];
  logic        perr_s [2];

  mem_responder #(
    .DEPTH_LOG2(10),
    .WAIT_CYCLES(2)
  ) u_dut2 (
    .clk(clk),
    .rst_n(rst_s[0]),
    .mem_read(rd_s[0]),
    .mem_write(wr_s[0]),
    .mem_byte_enable(be_s[0]),
    .mem_address(addr_s[0]),
    .mem_wdata(wdat_s[0]),
    .mem_rdata(rdat_s[0]),
    .mem_resp(resp_s[0]),
    .busy(bsy_s[0]),
    .proto_err(perr_s[0])
  );

  mem_responder #(
    .DEPTH_LOG2(10),
    .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk),
    .rst_n(rst_s[1]),
    .mem_read(rd_s[1]),
    .mem_write(wr_s[1]),
    .mem_byte_enable(be_s[1]),
    .mem_address(addr_s[1]),
    .mem_wdata(wdat_s[1]),
    .mem_rdata(rdat_s[1]),
    .mem_resp(resp_s[1]),
    .busy(bsy_s[1]),
    .proto_err(perr_s[1])
  );

  // Reference model: word contents, per-byte known flags, held rdata
  logic [15:0] m_mem [2][1024];
  logic [1:0]  m_kn  [2][1024];
  logic [15:0] m_rd  [2];
  bit          m_rdk [2];
  bit          m_pe  [2];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int wc(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int s);
    m_rd[s]  = 16'h0;
    m_rdk[s] = 1'b1;
    m_pe[s]  = 1'b0;
  endtask

  task automatic idle_inputs(input int s);
    rd_s[s]   = 1'b0;
    wr_s[s]   = 1'b0;
    be_s[s]   = 2'b00;
    addr_s[s] = 16'h0;
    wdat_s[s] = 16'h0;
  endtask

  // One full transaction starting in the current cycle (cycle 0)
  task automatic txn(input int s, input bit r, input bit w,
                     input logic [15:0] a, input logic [1:0] b,
                     input logic [15:0] d);
    int i;
    int lat;
    i   = int'(a[10:1]);
    lat = -1;
    rd_s[s]   = r;
    wr_s[s]   = w;
    addr_s[s] = a;
    be_s[s]   = b;
    wdat_s[s] = d;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (resp_s[s] === 1'b1) begin
        lat = c;
        break;
      end
      if (c <= wc(s)) chk("busy_wait", bsy_s[s], 1'b1);
    end
    chk("latency", lat, wc(s) + 1);
    chk("busy_resp", bsy_s[s], 1'b1);
    if (w) begin
      if (b[0]) begin
        m_mem[s][i][7:0] = d[7:0];
        m_kn[s][i][0]    = 1'b1;
      end
      if (b[1]) begin
        m_mem[s][i][15:8] = d[15:8];
        m_kn[s][i][1]     = 1'b1;
      end
      if (r) m_pe[s] = 1'b1;
    end else if (r) begin
      m_rd[s]  = m_mem[s][i];
      m_rdk[s] = (m_kn[s][i] == 2'b11);
    end
    if (m_rdk[s]) chk("rdata", rdat_s[s], m_rd[s]);
    chk("proto_err", perr_s[s], m_pe[s]);
    rd_s[s] = 1'b0;
    wr_s[s] = 1'b0;
    step();
    chk("resp_pulse", resp_s[s], 1'b0);
    chk("busy_idle", bsy_s[s], 1'b0);
  endtask

  // Read raised in cycle 0 and dropped at the start of cycle k
  task automatic abort_rd(input int s, input logic [15:0] a, input int k);
    rd_s[s]   = 1'b1;
    addr_s[s] = a;
    for (int c = 1; c <= k; c++) begin
      step();
      chk("ab_busy", bsy_s[s], 1'b1);
      chk("ab_resp", resp_s[s], 1'b0);
    end
    rd_s[s] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("ab_idle", bsy_s[s], 1'b0);
      chk("ab_noresp", resp_s[s], 1'b0);
    end
    if (m_rdk[s]) chk("ab_rhold", rdat_s[s], m_rd[s]);
  endtask

  task automatic chk_reset_outs(input int s);
    chk("rst_rdata", rdat_s[s], 16'h0);
    chk("rst_resp", resp_s[s], 1'b0);
    chk("rst_busy", bsy_s[s], 1'b0);
    chk("rst_perr", perr_s[s], 1'b0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    int          op;

    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b0;
      idle_inputs(s);
      model_reset(s);
      for (int j = 0; j < 1024; j++) begin
        m_mem[s][j] = 16'h0;
        m_kn[s][j]  = 2'b00;
      end
    end
    step();
    step();
    chk_reset_outs(0);
    chk_reset_outs(1);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    step();

    // Full write then read-back, then byte lanes
    txn(0, 1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF);
    txn(0, 1'b1, 1'b0, 16'h0011, 2'b00, 16'h0000);
    chk("beef", rdat_s[0], 16'hBEEF);
    txn(0, 1'b0, 1'b1, 16'h0010, 2'b01, 16'h12AB);
    txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    chk("beab", rdat_s[0], 16'hBEAB);
    txn(0, 1'b0, 1'b1, 16'h0010, 2'b10, 16'h5600);
    txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    chk("56ab", rdat_s[0], 16'h56AB);
    txn(0, 1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF);
    txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);
    chk("mask00", rdat_s[0], 16'h56AB);

    // Abort from WAIT, then a normal read
    abort_rd(0, 16'h0020, 2);
    chk("ab_keep", rdat_s[0], 16'h56AB);
    abort_rd(0, 16'h0020, 1);
    txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);

    // Read and write together
    txn(0, 1'b1, 1'b1, 16'h0020, 2'b11, 16'h7777);
    chk("perr_set", perr_s[0], 1'b1);
    txn(0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000);
    chk("rw_data", rdat_s[0], 16'h7777);
    chk("perr_sticky", perr_s[0], 1'b1);

    // Reset in the middle of a write
    txn(0, 1'b0, 1'b1, 16'h0030, 2'b11, 16'h1111);
    wr_s[0]   = 1'b1;
    addr_s[0] = 16'h0030;
    be_s[0]   = 2'b11;
    wdat_s[0] = 16'hAAAA;
    step();
    chk("rst_inflight", bsy_s[0], 1'b1);
    rst_s[0] = 1'b0;
    idle_inputs(0);
    #1;
    chk_reset_outs(0);
    model_reset(0);
    step();
    step();
    chk_reset_outs(0);
    rst_s[0] = 1'b1;
    step();
    txn(0, 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0000);
    chk("rst_dropped", rdat_s[0], 16'h1111);

    // Zero wait states: aliasing and back-to-back
    txn(1, 1'b0, 1'b1, 16'h0010, 2'b11, 16'hCAFE);
    txn(1, 1'b1, 1'b0, 16'h0810, 2'b00, 16'h0000);
    chk("alias", rdat_s[1], 16'hCAFE);
    txn(1, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000);

    // Random traffic over a small overlapping window of words
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 300; n++) begin
        a       = 16'($urandom);
        a[10:1] = 10'($urandom_range(8, 23));
        d       = 16'($urandom);
        b       = 2'($urandom);
        op      = int'($urandom_range(0, 99));
        if (s == 0 && op < 10) begin
          abort_rd(s, a, int'($urandom_range(1, 2)));
        end else if (op < 13) begin
          txn(s, 1'b1, 1'b1, a, b, d);
        end else if (op < 56) begin
          txn(s, 1'b0, 1'b1, a, b, d);
        end else begin
          txn(s, 1'b1, 1'b0, a, b, d);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the LC-3b core's `mem_*` request interface. It services word reads and byte-masked writes from an on-chip word array, with a parameterized number of wait states, and pulses `mem_resp` to complete each transaction. It sits directly on the core's memory port and stands in for a cache or arbiter during core bring-up.

## Interface
- `DEPTH_LOG2`, 10, log2 of array depth in 16-bit words.
- `WAIT_CYCLES`, 2, number of wait states inserted between request acceptance and response; 0 is legal.

- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  read request, held by the initiator until `mem_resp`.
- `mem_write`  in  1  write request, held by the initiator until `mem_resp`.
- `mem_byte_enable`  in  2  write byte mask (lc3b_mem_wmask); bit0 is the low byte and bit1 the high byte.
- `mem_address`  in  16  byte address; bit 0 is ignored.
- `mem_wdata`  in  16  write data.
- `mem_rdata`  out  16  read data; valid while `mem_resp`=1.
- `mem_resp`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in WAIT and RESP.
- `proto_err`  out  1  sticky flag: `mem_read` and `mem_write` were seen together.

## Operation
- Word index is `mem_address[DEPTH_LOG2:1]`; higher address bits are ignored and the array aliases.
- Array contents are not reset; their state after power-up is undefined.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, request (`mem_read | mem_write`) high, `WAIT_CYCLES`=0: commit, then go to RESP.
  - IDLE, request high, `WAIT_CYCLES`>0: load counter with `WAIT_CYCLES`-1, then go to WAIT.
  - WAIT, request low: abort and go to IDLE. No write, no response, `mem_rdata` unchanged.
  - WAIT, counter=0, request high: commit, then go to RESP.
  - WAIT, otherwise: decrement the counter.
  - RESP: `mem_resp`=1 for exactly one cycle, then go to IDLE unconditionally.
- Commit happens at the edge entering RESP. Address, data and mask are sampled at that edge; the initiator holds them stable.
  - Write: array bytes written only where the mask bit is 1. Mask 00 still completes with no change.
  - Read: `mem_rdata` loads the array word. Read-after-write to the same word returns the new data.
- `mem_rdata` holds its last read value through IDLE, WAIT and writes.
- Both request signals high at commit:
  - treated as a write;
  - `proto_err` sets at that edge and stays set until reset.
- Counter width is `$clog2(WAIT_CYCLES+1)`, minimum 1 bit. It never underflows.

## Timing
- Reset values: state IDLE, `mem_resp`=0, `mem_rdata`=0, `busy`=0, `proto_err`=0, counter=0.
- Assertion of `rst_n`=0 takes effect immediately, including mid-transaction. An in-flight write is dropped.
- Latency: request high in cycle 0 gives `mem_resp` high in cycle `WAIT_CYCLES`+1.
  - `WAIT_CYCLES`=2: response in cycle 3.
  - `WAIT_CYCLES`=0: response in cycle 1.
- The initiator drops its request in the cycle after `mem_resp`. A request still high in the cycle after RESP starts a new transaction.
- Back-to-back transactions: throughput is one per `WAIT_CYCLES`+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- `WAIT_CYCLES`=2, write 0xBEEF to 0x0010 with mask 11, request from cycle 0:
  - `mem_resp` pulses in cycle 3 only; `busy` is high in cycles 1–3.
  - A following read of 0x0011 returns 0xBEEF with `mem_resp`.
- Byte lanes:
  - Write 0x12AB with mask 01 to 0x0010, then read: 0xBEAB.
  - Write 0x5600 with mask 10, then read: 0x56AB.
  - Write with mask 00, then read: still 0x56AB.
- Abort: drop `mem_read` after 1 cycle in WAIT.
  - No `mem_resp`, `busy` returns to 0, `mem_rdata` unchanged.
  - The next full read completes with the normal latency.
- `mem_read` and `mem_write` high together, wdata 0x7777 to 0x0020:
  - `proto_err` = 1 after the commit and stays set;
  - a read of 0x0020 then returns 0x7777.
- Reset: `rst_n` low during WAIT of a write of 0xAAAA to 0x0030 (location previously 0x1111).
  - Outputs go to reset values immediately; the bench holds `mem_read`/`mem_write` low while `rst_n` is low, then releases reset.
  - A read of 0x0030 returns 0x1111.
- Aliasing with `DEPTH_LOG2`=10 and `WAIT_CYCLES`=0:
  - Read 0x0810 returns the word at 0x0010.
  - `mem_resp` arrives in cycle 1.
  - An immediately following request completes with the same one-cycle latency.
